// File: rtl/ascon_pack.sv
// Shared round-counter types and round constants for the permutation datapath.
// Holds the FSM state encoding and the p^a / p^b start and terminal round indices.
package ascon_pack;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } round_state_t;

   localparam int ROUND_A_START = 0;
   localparam int ROUND_B_START = 6;
   localparam int ROUND_LAST    = 11;

endpackage

// File: rtl/compteur_round_param.sv
// Round counter for p^a / p^b runs: starts take effect on the next edge, counts on en_i, one-cycle done pulse.
// No backpressure: en_i stalls the count, start requests always win (restart mid-run allowed).
module compteur_round_param
   import ascon_pack::*;
#(
   parameter int WIDTH    = 4,
   parameter int LAST_VAL = ROUND_LAST,
   parameter int START_B  = ROUND_B_START,
   parameter int WRAP_EN  = 0
) (
   input  logic             clock_i,
   input  logic             resetb_i,
   input  logic             en_i,
   input  logic             init_a_i,
   input  logic             init_b_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o,
   output logic             done_o,
   output logic             busy_o
);

   if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
      $fatal(1, "compteur_round_param: WIDTH must be in 2..8");
   end
   if (LAST_VAL < 0 || LAST_VAL >= (1 << WIDTH)) begin : g_bad_last
      $fatal(1, "compteur_round_param: LAST_VAL must be below 2**WIDTH");
   end
   if (START_B < 0 || START_B > LAST_VAL) begin : g_bad_start
      $fatal(1, "compteur_round_param: START_B must not exceed LAST_VAL");
   end

   localparam logic [WIDTH-1:0] LAST_W    = WIDTH'(LAST_VAL);
   localparam logic [WIDTH-1:0] START_A_W = WIDTH'(ROUND_A_START);
   localparam logic [WIDTH-1:0] START_B_W = WIDTH'(START_B);
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

   round_state_t     state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] start_val;
   logic             done_q, done_d;
   logic             busy_q;
   logic             start;
   logic             at_last;
   logic             terminal;

   assign start    = init_a_i | init_b_i | load_i;
   assign at_last  = (data_q == LAST_W);
   assign terminal = (state_q == ST_RUN) && en_i && at_last;

   // Start value follows init_a > init_b > load priority; loads beyond the terminal round clamp.
   always_comb begin
      start_val = START_A_W;
      if (init_a_i)
         start_val = START_A_W;
      else if (init_b_i)
         start_val = START_B_W;
      else if (load_val_i > LAST_W)
         start_val = LAST_W;
      else
         start_val = load_val_i;
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         done_q  <= done_d;
         busy_q  <= (state_d == ST_RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      if (start)
         state_d = ST_RUN;
      else begin
         case (state_q)
            ST_RUN:  if (terminal) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A start on the terminal cycle suppresses the done pulse.
   always_comb begin
      data_d = data_q;
      done_d = 1'b0;
      if (start)
         data_d = start_val;
      else if ((state_q == ST_RUN) && en_i) begin
         if (at_last) begin
            done_d = 1'b1;
            data_d = (WRAP_EN != 0) ? '0 : LAST_W;
         end else begin
            data_d = data_q + ONE_W;
         end
      end
   end

   assign data_o = data_q;
   assign done_o = done_q;
   assign busy_o = busy_q;
   assign last_o = (state_q == ST_RUN) && at_last;

endmodule

// File: doc/compteur_round_param.md
COMPTEUR_ROUND_PARAM -- requirements
Module: compteur_round_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..8.
REQ-002 Parameter LAST_VAL, default 11: terminal count value; SHALL satisfy LAST_VAL < 2**WIDTH.
REQ-003 Parameter START_B, default 6: start value for the reduced-round (p^b) permutation; SHALL satisfy START_B <= LAST_VAL.
REQ-004 Parameter WRAP_EN, default 0: 1 = wrap to 0 after LAST_VAL; 0 = saturate at LAST_VAL.
REQ-005 clock_i  input  1  clock; all state updates on the rising edge.
REQ-006 resetb_i  input  1  reset, asynchronous, active-low.
REQ-007 en_i  input  1  count enable; qualifies increment only.
REQ-008 init_a_i  input  1  synchronous start of a p^a run at value 0.
REQ-009 init_b_i  input  1  synchronous start of a p^b run at value START_B.
REQ-010 load_i  input  1  synchronous start of a run at load_val_i.
REQ-011 load_val_i  input  WIDTH  value loaded when load_i = 1; values above LAST_VAL are clamped to LAST_VAL.
REQ-012 data_o  output  WIDTH  current count (round index).
REQ-013 last_o  output  1  combinational, 1 when data_o == LAST_VAL and state is RUN.
REQ-014 done_o  output  1  registered, one-cycle pulse when the final round has been counted.
REQ-015 busy_o  output  1  1 while state is RUN.

Function
REQ-016 FSM states: IDLE, RUN, DONE; the state encoding SHALL be an enumerated type.
REQ-017 Start priority: init_a_i > init_b_i > load_i; start requests act regardless of en_i and of the current state, including mid-run (restart).
REQ-018 On a start request: data_o <= start value, state <= RUN, done_o <= 0 on the next edge.
REQ-019 RUN, no start request, en_i = 1, data_o < LAST_VAL: data_o <= data_o + 1.
REQ-020 RUN, no start request, en_i = 1, data_o == LAST_VAL: done_o <= 1 for exactly one cycle; state <= DONE; data_o <= 0 if WRAP_EN = 1, else data_o holds LAST_VAL.
REQ-021 RUN with en_i = 0: data_o and state hold.
REQ-022 DONE: data_o holds; en_i is ignored; without a start request, the state moves to IDLE on the next edge.
REQ-023 IDLE: data_o holds; en_i is ignored; only a start request leaves IDLE.
REQ-024 Increment arithmetic is modulo 2**WIDTH internally; data_o SHALL never exceed LAST_VAL.
REQ-025 A start value equal to LAST_VAL is legal: last_o is 1 on the first RUN cycle, and the next enabled cycle produces done_o.
REQ-026 A start request coinciding with the terminal increment wins: no done_o pulse, the new run begins.

Reset
REQ-027 resetb_i = 0 asynchronously forces state IDLE, data_o = 0, done_o = 0, busy_o = 0, last_o = 0.
REQ-028 Reset asserted mid-run aborts the run with no done_o pulse; operation resumes only on a start request after release.

Structure
REQ-029 The shared package ascon_pack SHALL hold the state enum typedef and the constants ROUND_A_START = 0, ROUND_B_START = 6, ROUND_LAST = 11.
REQ-030 The block SHALL be a single module with no sub-module; last_o is decoded combinationally, all other outputs are registered.
REQ-031 Parameter legality (REQ-001..REQ-003) SHALL be checked at elaboration with a fatal error.

Verification
REQ-032 Defaults, init_a_i pulse, then en_i held high -> data_o 0,1,...,11; last_o high at 11; done_o single pulse on the following edge; busy_o falls; data_o stays 11.
REQ-033 init_b_i pulse, en_i high -> data_o 6..11, six counted rounds, then done_o single pulse.
REQ-034 WRAP_EN = 1, run to LAST_VAL -> data_o returns to 0 in the same cycle as the done_o pulse; state goes DONE then IDLE.
REQ-035 init_a_i and load_i (load_val_i = 9) together, then init_b_i at count 8 -> counts 0,...; restart to 6; exactly one done_o for the whole sequence.
REQ-036 en_i toggled randomly during RUN -> data_o increments only on cycles with en_i = 1; load_val_i = 15 -> clamped to 11.
REQ-037 resetb_i pulsed low at count 5, asynchronously off the clock edge -> immediate data_o = 0, busy_o = 0; no done_o pulse; en_i then has no effect until a start request.
